// File: rtl/fir_pkg.sv
// Shared widths, FSM state encodings and counter-width helper for the FIR output path.
package fir_pkg;

   localparam int unsigned FIR_DATA_WIDTH   = 32;
   localparam int unsigned FIR_ACC_WIDTH    = 40;
   localparam int unsigned FIR_MAX_DATA_NUM = 1024;
   localparam int unsigned FIR_FIFO_DEPTH   = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   function automatic int unsigned fir_cnt_width(input int unsigned max_num);
      return $clog2(max_num + 1);
   endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Synchronous result buffer: registered storage, wrapping pointers, occupancy counter.
module fir_sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [WIDTH-1:0] o_head
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_head  = r_mem[r_rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
         else if (!w_push && w_pop) r_count <= r_count - (AW+1)'(1);
      end
   end

endmodule

// File: rtl/fir_stream_out.sv
// FIR output stage: buffers MAC results and drives an AXI4-Stream master with frame tlast/ap_done.
// Optional macro FIR_OUT_SAT_EN saturates results to the signed output range instead of truncating.
module fir_stream_out
   import fir_pkg::*;
#(
   parameter int unsigned pDATA_WIDTH  = FIR_DATA_WIDTH,
   parameter int unsigned pACC_WIDTH   = FIR_ACC_WIDTH,
   parameter int unsigned MAX_DATA_NUM = FIR_MAX_DATA_NUM,
   parameter int unsigned FIFO_DEPTH   = FIR_FIFO_DEPTH
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic                                      ap_start,
   input  logic [fir_cnt_width(MAX_DATA_NUM)-1:0]    data_num,
   output logic                                      ap_done,
   input  logic                                      res_valid,
   input  logic [pACC_WIDTH-1:0]                     res_data,
   output logic                                      res_ready,
   output logic                                      sm_tvalid,
   input  logic                                      sm_tready,
   output logic [pDATA_WIDTH-1:0]                    sm_tdata,
   output logic                                      sm_tlast
);

   localparam int unsigned CW = fir_cnt_width(MAX_DATA_NUM);

   logic [1:0]             r_state;
   logic [CW-1:0]          r_data_num;
   logic [CW-1:0]          r_in_cnt;
   logic [CW-1:0]          r_out_cnt;
   logic                   r_done;

   logic                   w_fifo_full;
   logic                   w_fifo_empty;
   logic [pDATA_WIDTH-1:0] w_head;
   logic [pDATA_WIDTH-1:0] w_push_data;
   logic                   w_res_ready;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_tlast;

   assign w_res_ready = (r_state == ST_RUN) && !w_fifo_full && (r_in_cnt < r_data_num);
   assign w_push      = res_valid && w_res_ready;
   assign w_pop       = !w_fifo_empty && sm_tready;
   assign w_tlast     = !w_fifo_empty && (r_out_cnt == (r_data_num - CW'(1)));

`ifdef FIR_OUT_SAT_EN
   localparam logic [pDATA_WIDTH-1:0] SAT_MAX = {1'b0, {(pDATA_WIDTH-1){1'b1}}};
   localparam logic [pDATA_WIDTH-1:0] SAT_MIN = {1'b1, {(pDATA_WIDTH-1){1'b0}}};

   // Out of range whenever the bits above the output sign bit are not a pure sign extension.
   always_comb begin
      w_push_data = res_data[pDATA_WIDTH-1:0];
      if (res_data[pACC_WIDTH-1:pDATA_WIDTH-1] != {(pACC_WIDTH-pDATA_WIDTH+1){res_data[pACC_WIDTH-1]}})
         w_push_data = res_data[pACC_WIDTH-1] ? SAT_MIN : SAT_MAX;
   end
`else
   logic w_unused_hi;
   assign w_unused_hi = ^res_data[pACC_WIDTH-1:pDATA_WIDTH];
   assign w_push_data = res_data[pDATA_WIDTH-1:0];
`endif

   fir_sync_fifo #(
      .WIDTH (pDATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_push_data),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_head  (w_head)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_data_num <= '0;
         r_in_cnt   <= '0;
         r_out_cnt  <= '0;
         r_done     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (ap_start) begin
                  r_data_num <= data_num;
                  r_in_cnt   <= '0;
                  r_out_cnt  <= '0;
                  r_done     <= 1'b0;
                  r_state    <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_push) r_in_cnt  <= r_in_cnt + CW'(1);
               if (w_pop)  r_out_cnt <= r_out_cnt + CW'(1);
               // Zero-length frames pass through RUN for one cycle and finish without a beat.
               if ((r_data_num == '0) || (w_pop && w_tlast)) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign ap_done   = r_done;
   assign res_ready = w_res_ready;
   assign sm_tvalid = !w_fifo_empty;
   assign sm_tdata  = w_head;
   assign sm_tlast  = w_tlast;

endmodule
